// File: rtl/bit_scan_ctrl_if.sv
// Producer-side handshake and result bus for bit_scan_ctrl.
// master = word producer, slave = bit_scan_ctrl.
interface bit_scan_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [WORD_W-1:0] word;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  hit_count;
  logic              hit_any;
  logic [IDX_W-1:0]  first_idx;

  modport master (
    output start, word,
    input  busy, done, hit_count, hit_any, first_idx
  );

  modport slave (
    input  start, word,
    output busy, done, hit_count, hit_any, first_idx
  );
endinterface

// File: rtl/bit_scan_ctrl.sv
// Serialises a word into a single-bit Moore detector and collects hit statistics.
// Build option: define BIT_SCAN_LSB_FIRST_EN to shift LSB first (default MSB first).
module bit_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_scan_ctrl_if.slave       bus,
  output logic                 det_rst,
  output logic                 det_in,
  input  logic                 det_z
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [IDX_W-1:0]  k;
  logic              busy_q;
  logic              done_q;
  logic              det_in_q;
  logic [CNT_W-1:0]  hit_count_q;
  logic              hit_any_q;
  logic [IDX_W-1:0]  first_idx_q;

  logic              out_bit;
  logic [WORD_W-1:0] sr_next;
  logic              sample_en;
  logic [IDX_W-1:0]  sample_idx;

`ifdef BIT_SCAN_LSB_FIRST_EN
  assign out_bit = sr[0];
  assign sr_next = {1'b0, sr[WORD_W-1:1]};
`else
  assign out_bit = sr[WORD_W-1];
  assign sr_next = {sr[WORD_W-2:0], 1'b0};
`endif

  // det_z lags det_in by one cycle: SHIFT cycle k sees bit k-1, DRAIN sees the last bit.
  always_comb begin
    sample_en  = 1'b0;
    sample_idx = '0;
    if (state == SHIFT && k != '0) begin
      sample_en  = 1'b1;
      sample_idx = k - 1'b1;
    end else if (state == DRAIN) begin
      sample_en  = 1'b1;
      sample_idx = LAST_IDX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      k           <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_in_q    <= 1'b0;
      hit_count_q <= '0;
      hit_any_q   <= 1'b0;
      first_idx_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (sample_en && det_z) begin
        if (hit_count_q != '1)
          hit_count_q <= hit_count_q + 1'b1;
        if (!hit_any_q) begin
          hit_any_q   <= 1'b1;
          first_idx_q <= sample_idx;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            sr     <= bus.word;
            busy_q <= 1'b1;
            state  <= CLR;
          end
        end
        CLR: begin
          hit_count_q <= '0;
          hit_any_q   <= 1'b0;
          first_idx_q <= '0;
          k           <= '0;
          det_in_q    <= out_bit;
          sr          <= sr_next;
          state       <= SHIFT;
        end
        SHIFT: begin
          if (k == LAST_IDX) begin
            det_in_q <= 1'b0;
            state    <= DRAIN;
          end else begin
            det_in_q <= out_bit;
            sr       <= sr_next;
            k        <= k + 1'b1;
          end
        end
        DRAIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign det_rst       = rst | (state == CLR);
  assign det_in        = det_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hit_count_q;
  assign bus.hit_any   = hit_any_q;
  assign bus.first_idx = first_idx_q;

endmodule

// File: doc/bit_scan_ctrl.md
# bit_scan_ctrl

Sequencer that feeds a parallel data word, one bit per cycle, into the team's shared single-bit Moore pattern detector and collects the result. It resets the detector, shifts the word out, samples the detector's registered `z` output with the correct one-cycle alignment, and reports a saturating hit count plus the bit index of the first hit. It sits between a word-oriented producer (start/done handshake) and any serial Moore detector with a synchronous reset.

## Interface

Parameters:

- `WORD_W`, default 16: bits per scanned word, ≥2.
- `IDX_W`, default 4: width of the index output; 2^IDX_W ≥ WORD_W.
- `CNT_W`, default 5: width of the hit counter.

Ports:

- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: request a scan; sampled only in IDLE.
- `word` in WORD_W: data to scan; captured on the accepting edge.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse; results valid.
- `det_rst` out 1: synchronous reset to the detector.
- `det_in` out 1: serial bit to the detector.
- `det_z` in 1: detector Moore output.
- `hit_count` out CNT_W: number of sampled `det_z`=1 cycles, saturating.
- `hit_any` out 1: at least one hit in the last scan.
- `first_idx` out IDX_W: index (0-based, in shift order) of the bit after which the first hit appeared; 0 when `hit_any`=0.

## Operation

- States: IDLE, CLR, SHIFT, DRAIN.
- IDLE: `busy`=0, `det_in`=0. If `start`=1, latch `word` into the shift register and go to CLR.
- CLR (1 cycle):
  - `busy`=1, `det_rst`=1.
  - Clear `hit_count`, `hit_any`, `first_idx`, and the bit counter `k`.
- SHIFT (WORD_W cycles, k=0..WORD_W-1):
  - `det_in` = bit k. Shift order is MSB first (bit WORD_W-1 is k=0).
  - In cycles k≥1, `det_z` reflects the detector state after bit k-1; sample it as a hit for index k-1.
  - The k=0 cycle is not sampled.
  - After k=WORD_W-1, go to DRAIN.
- DRAIN (1 cycle): `det_in`=0. Sample `det_z` as a hit for index WORD_W-1, then go to IDLE.
- On each hit:
  - `hit_count` increments and holds at 2^CNT_W-1 when saturated.
  - On the first hit, set `hit_any`=1 and `first_idx`=index.
- `done`=1 for exactly the first IDLE cycle after DRAIN. `hit_count`, `hit_any` and `first_idx` hold until the next CLR.
- `start` while busy is ignored and not queued. `start` in the `done` cycle is accepted.
- `word` changes while busy have no effect.
- `det_rst` = 1 when `rst`=1 or the state is CLR; otherwise 0.

## Timing

- Reset: state IDLE, `busy`=0, `done`=0, `det_in`=0, `hit_count`=0, `hit_any`=0, `first_idx`=0; `det_rst`=1 while `rst`=1.
- `rst` mid-scan aborts on the next edge. No `done` is generated, and results clear to 0.
- Start accepted at edge E. CLR is cycle E+1, SHIFT is E+2..E+WORD_W+1, DRAIN is E+WORD_W+2, `done` is E+WORD_W+3.
- `busy` is high for WORD_W+2 cycles. Back-to-back scans have a period of WORD_W+3 cycles.
- All outputs are registered except `det_rst`. `det_rst` is combinational from `rst` and the state register.
- `det_z` is sampled at the clock edge ending each sampled cycle. Results update on that edge and are visible in the next cycle.

## Configuration

- `BIT_SCAN_LSB_FIRST_EN`:
  - Defined: shift order is LSB first (bit 0 is k=0), and `first_idx` counts in that order.
  - Undefined: MSB first as above.
- All other behaviour is identical in both builds.

## Test plan

Unless a scenario says otherwise, the bench connects the team's 11/101/1011 Moore detector (z=1 in its "11", "10 after 1" and "1011/…11" output states) with WORD_W=8.

- Single scan: `word`=8'b1101_0000, MSB first, pulse `start` → `det_in` sequence 1,1,0,1,0,0,0,0; `done` 11 cycles after the start edge; `hit_count`=2, `hit_any`=1, `first_idx`=1.
- No hits: `word`=8'h00 → `hit_count`=0, `hit_any`=0, `first_idx`=0; `det_rst` high exactly in the CLR cycle.
- Saturation: CNT_W=3, `word`=8'hFF → 7 raw hits (indices 1..7) → `hit_count`=7, `first_idx`=1. Repeat with CNT_W=2 → `hit_count`=3.
- Handshake:
  - `start` held high continuously → a new CLR begins in each `done` cycle, with period 11.
  - `start` pulsed mid-SHIFT → ignored; the result is unchanged.
- Reset mid-scan: assert `rst` in SHIFT k=4 → next cycle all outputs 0, no `done`; `det_rst`=1 while `rst` is high; a following scan gives correct results.
- `BIT_SCAN_LSB_FIRST_EN` defined, `word`=8'b0000_1011 → `det_in` sequence 1,1,0,1,0,0,0,0; `hit_count`=2, `first_idx`=1.
